// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: sequences an external up/down counter through a
// programmed number of low->up->low sweeps, with pause, abort and a
// one-cycle dwell at every turning point.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; limits/cycles captured on accept
// SEEK   | walking the counter to the registered low limit
// UP     | stepping the counter up to the registered up limit
// DOWN   | stepping the counter back down to the registered low limit
// DONE   | one-cycle completion pulse, then back to IDLE
module counter_sweep_ctrl #(
    parameter int WIDTH = 8,
    parameter int CYC_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic [WIDTH-1:0] low_limit,
    input  logic [WIDTH-1:0] up_limit,
    input  logic [CYC_W-1:0] cycles,
    input  logic [WIDTH-1:0] count,
    output logic             cnt_enable,
    output logic             cnt_dir,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CYC_W-1:0] sweep_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEEK,
        S_UP,
        S_DOWN,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_MIN = '0;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] low_q;
    logic [WIDTH-1:0] up_q;
    logic [CYC_W-1:0] cyc_q;
    logic [CYC_W-1:0] idx_nxt;
    logic [CYC_W:0]   idx_inc;
    logic             capture;
    logic             err_q;
    logic             err_nxt;

    // One extra bit so the "more sweeps to go" compare cannot wrap.
    assign idx_inc = {1'b0, sweep_idx} + {{CYC_W{1'b0}}, 1'b1};

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Captured program, sweep counter and error pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            low_q     <= '0;
            up_q      <= '0;
            cyc_q     <= '0;
            sweep_idx <= '0;
            err_q     <= 1'b0;
        end else begin
            if (capture) begin
                low_q <= low_limit;
                up_q  <= up_limit;
                cyc_q <= cycles;
            end
            sweep_idx <= idx_nxt;
            err_q     <= err_nxt;
        end
    end

    // Next-state and counter control; enable/dir stay combinational so the
    // counter stops on the very edge it would reach a limit.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = sweep_idx;
        cnt_enable = 1'b0;
        cnt_dir    = 1'b1;
        capture    = 1'b0;
        err_nxt    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (low_limit >= up_limit) begin
                        err_nxt = 1'b1;
                    end else begin
                        capture   = 1'b1;
                        idx_nxt   = '0;
                        state_nxt = S_SEEK;
                    end
                end
            end
            S_SEEK: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (!pause) begin
                    if (count < low_q) begin
                        cnt_enable = 1'b1;
                    end else if (count > low_q) begin
                        cnt_enable = 1'b1;
                        cnt_dir    = 1'b0;
                    end else begin
                        // Dwell cycle: enable low, advance on this edge.
                        state_nxt = (cyc_q == '0) ? S_DONE : S_UP;
                    end
                end
            end
            S_UP: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (!pause) begin
                    if (count == up_q) begin
                        state_nxt = S_DOWN;
                    end else if (count != CNT_MAX) begin
                        cnt_enable = 1'b1;
                    end
                end
            end
            S_DOWN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (!pause) begin
                    if (count == low_q) begin
                        idx_nxt   = idx_inc[CYC_W-1:0];
                        state_nxt = (idx_inc < {1'b0, cyc_q}) ? S_UP : S_DONE;
                    end else if (count != CNT_MIN) begin
                        cnt_enable = 1'b1;
                        cnt_dir    = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign err  = err_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl. The bench owns the controlled
// counter and steps it from cnt_enable/cnt_dir; all checks happen on the
// falling edge, halfway between active edges.
module tb_counter_sweep_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       pause;
    logic [7:0] low_limit;
    logic [7:0] up_limit;
    logic [3:0] cycles;
    logic [7:0] count;
    logic       cnt_enable;
    logic       cnt_dir;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] sweep_idx;

    logic       ld;
    logic [7:0] ld_val;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] seq1 [18] = '{1, 2, 2, 3, 4, 5, 5, 4, 3, 2, 2, 3, 4, 5, 5, 4, 3, 2};

    counter_sweep_ctrl #(.WIDTH(8), .CYC_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .pause      (pause),
        .low_limit  (low_limit),
        .up_limit   (up_limit),
        .cycles     (cycles),
        .count      (count),
        .cnt_enable (cnt_enable),
        .cnt_dir    (cnt_dir),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .sweep_idx  (sweep_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controlled counter model.
    always @(posedge clk) begin
        if (ld) begin
            count <= ld_val;
        end else if (cnt_enable) begin
            count <= cnt_dir ? count + 8'd1 : count - 8'd1;
        end
    end

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: sim time exceeded, expected summary before timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] v);
        ld     = 1'b1;
        ld_val = v;
        @(negedge clk);
        ld     = 1'b0;
    endtask

    // Present a program and let edge E0 sample it; returns on the falling
    // edge right after E0.
    task automatic go(input logic [7:0] lo, input logic [7:0] hi, input logic [3:0] cy);
        low_limit = lo;
        up_limit  = hi;
        cycles    = cy;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    initial begin
        int k;
        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        pause     = 1'b0;
        low_limit = '0;
        up_limit  = '0;
        cycles    = '0;
        ld        = 1'b1;
        ld_val    = 8'd0;
        repeat (2) @(negedge clk);
        ld = 1'b0;

        // Reset values
        chk("rst_en",   cnt_enable, 0);
        chk("rst_dir",  cnt_dir,    1);
        chk("rst_busy", busy,       0);
        chk("rst_done", done,       0);
        chk("rst_err",  err,        0);
        chk("rst_idx",  sweep_idx,  0);
        reset = 1'b1;

        // Two full sweeps 2..5 from count 0; limits scrambled after capture
        load(8'd0);
        go(8'd2, 8'd5, 4'd2);
        chk("t1_busy", busy, 1);
        low_limit = 8'd0;
        up_limit  = 8'd200;
        cycles    = 4'd0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk($sformatf("t1_cnt%0d", i + 1), count, seq1[i]);
            chk($sformatf("t1_done%0d", i + 1), done, 0);
        end
        @(negedge clk);
        chk("t1_done_pulse", done, 1);
        chk("t1_idx", sweep_idx, 2);
        @(negedge clk);
        chk("t1_done_clr", done, 0);
        chk("t1_idle", busy, 0);
        chk("t1_idx_hold", sweep_idx, 2);

        // cycles==0, already at low: dwell then DONE
        load(8'd2);
        go(8'd2, 8'd5, 4'd0);
        chk("t2_en0", cnt_enable, 0);
        chk("t2_busy", busy, 1);
        chk("t2_nodone", done, 0);
        chk("t2_idx_clr", sweep_idx, 0);
        @(negedge clk);
        chk("t2_done", done, 1);
        chk("t2_en1", cnt_enable, 0);
        @(negedge clk);
        chk("t2_idle", busy, 0);

        // Rejected programs: low == up and low > up
        go(8'd5, 8'd5, 4'd3);
        chk("t3_err", err, 1);
        chk("t3_busy", busy, 0);
        chk("t3_en", cnt_enable, 0);
        @(negedge clk);
        chk("t3_err_clr", err, 0);
        chk("t3_busy2", busy, 0);
        go(8'd7, 8'd3, 4'd1);
        chk("t3_err_gt", err, 1);
        chk("t3_busy_gt", busy, 0);
        @(negedge clk);

        // Pause 3 cycles mid-UP: done moves from E11 to E14
        load(8'd0);
        go(8'd2, 8'd5, 4'd1);
        repeat (4) @(negedge clk);
        chk("t4_cnt_pre", count, 3);
        pause = 1'b1;
        #1;
        chk("t4_en_pause", cnt_enable, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t4_hold%0d", i), count, 3);
        end
        pause = 1'b0;
        k = 7;
        while (k < 40 && !done) begin
            @(negedge clk);
            k++;
        end
        chk("t4_len", k, 14);
        chk("t4_idx", sweep_idx, 1);
        @(negedge clk);

        // Abort mid-DOWN, then a fresh program seeking downward
        go(8'd2, 8'd5, 4'd1);
        repeat (6) @(negedge clk);
        chk("t5_cnt", count, 4);
        chk("t5_en", cnt_enable, 1);
        chk("t5_dir", cnt_dir, 0);
        abort = 1'b1;
        pause = 1'b1;
        #1;
        chk("t5_en_abort", cnt_enable, 0);
        chk("t5_dir_abort", cnt_dir, 1);
        @(negedge clk);
        abort = 1'b0;
        pause = 1'b0;
        chk("t5_idle", busy, 0);
        chk("t5_nodone", done, 0);
        chk("t5_cnt_hold", count, 4);
        @(negedge clk);
        chk("t5_nodone2", done, 0);
        go(8'd1, 8'd3, 4'd0);
        chk("t5_restart", busy, 1);
        chk("t5_seek_en", cnt_enable, 1);
        chk("t5_seek_dir", cnt_dir, 0);
        repeat (4) @(negedge clk);
        chk("t5_done", done, 1);
        chk("t5_cnt_end", count, 1);
        @(negedge clk);

        // Asynchronous reset mid-UP, then start on the first edge after release
        load(8'd1);
        go(8'd1, 8'd4, 4'd1);
        repeat (2) @(negedge clk);
        chk("t6_busy", busy, 1);
        chk("t6_en", cnt_enable, 1);
        chk("t6_cnt", count, 2);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_en", cnt_enable, 0);
        chk("t6_rst_dir", cnt_dir, 1);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_idx", sweep_idx, 0);
        @(negedge clk);
        reset = 1'b1;
        go(8'd2, 8'd3, 4'd1);
        chk("t6_accept", busy, 1);
        repeat (5) @(negedge clk);
        chk("t6_done", done, 1);
        chk("t6_idx", sweep_idx, 1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/counter_sweep_ctrl.md
COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the counter data width.
REQ-002 SHALL have parameter CYC_W, default 4, meaning the sweep-count field width.
REQ-003 SHALL have port clk  input  1  clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to run a sweep program; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  terminates the program from any non-IDLE state.
REQ-007 SHALL have port pause  input  1  freezes state and holds the counter while high.
REQ-008 SHALL have port low_limit  input  WIDTH  sweep floor; captured at start.
REQ-009 SHALL have port up_limit  input  WIDTH  sweep ceiling; captured at start.
REQ-010 SHALL have port cycles  input  CYC_W  number of full up/down sweeps; captured at start.
REQ-011 SHALL have port count  input  WIDTH  current value of the controlled counter.
REQ-012 SHALL have port cnt_enable  output  1  counter enable; counter steps on the next edge when high.
REQ-013 SHALL have port cnt_dir  output  1  counter direction: 1 = up, 0 = down.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse on normal completion.
REQ-016 SHALL have port err  output  1  one-cycle pulse on rejected program.
REQ-017 SHALL have port sweep_idx  output  CYC_W  number of completed sweeps in the current program.

Function
REQ-018 SHALL implement the states IDLE, SEEK, UP, DOWN, DONE.
REQ-019 In IDLE with start=1, SHALL register the limits and cycles, clear sweep_idx and go to SEEK; if low_limit >= up_limit, SHALL instead pulse err for one cycle and stay in IDLE.
REQ-020 SEEK SHALL drive the counter toward the registered low value: count<low -> enable=1, dir=1; count>low -> enable=1, dir=0.
REQ-021 UP SHALL drive enable=1, dir=1 while count != up.
REQ-022 DOWN SHALL drive enable=1, dir=0 while count != low.
REQ-023 cnt_enable and cnt_dir SHALL be combinational from the state and count, so the counter never overshoots a limit.
REQ-024 On reaching the target (SEEK/DOWN: count==low; UP: count==up), the block SHALL drive enable=0 for exactly one dwell cycle and advance at the end of that cycle.
REQ-025 Transitions: SEEK->UP; UP->DOWN; DOWN -> sweep_idx+1, then UP if sweep_idx+1 < cycles, else DONE.
REQ-026 If cycles==0, the block SHALL go SEEK->DONE after the SEEK dwell cycle, with no UP or DOWN phase.
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE; sweep_idx SHALL hold its final value until the next accepted start.
REQ-028 cnt_dir SHALL be 1 whenever cnt_enable=0.
REQ-029 pause=1 SHALL force cnt_enable=0 and freeze the state and sweep_idx; pause SHALL be ignored in IDLE and DONE.
REQ-030 abort=1 in SEEK, UP or DOWN SHALL force cnt_enable=0 that cycle and go to IDLE on the next edge, with no done or err pulse.
REQ-031 abort SHALL take priority over pause.
REQ-032 start outside IDLE SHALL be ignored, and limit changes after capture SHALL have no effect.
REQ-033 Equality compares SHALL be full WIDTH, unsigned, and the block SHALL never drive the counter past 0 or 2^WIDTH-1.

Reset
REQ-034 reset=0 SHALL, asynchronously, force IDLE, cnt_enable=0, cnt_dir=1, busy=0, done=0, err=0, sweep_idx=0, and clear the registered limits.
REQ-035 Reset asserted mid-program SHALL abort it with no done pulse.
REQ-036 After reset release, the block SHALL accept start on the first rising edge.

Verification
REQ-037 Scenario: count=0, low=2, up=5, cycles=2, start at edge E0 -> counter sequence 1,2,2,3,4,5,5,4,3,2,2,3,4,5,5,4,3,2; done high only in the cycle after E19; sweep_idx=2.
REQ-038 Scenario: count=2, low=2, up=5, cycles=0 -> one dwell cycle, then DONE; cnt_enable never high; done 2 cycles after start.
REQ-039 Scenario: low=5, up=5 start -> err pulse 1 cycle, busy stays 0, cnt_enable stays 0.
REQ-040 Scenario: pause high for 3 cycles mid-UP -> count holds 3 cycles and total program length grows by exactly 3 cycles.
REQ-041 Scenario: abort mid-DOWN -> cnt_enable=0 immediately, IDLE next edge, no done; a new start is then accepted.
REQ-042 Scenario: reset=0 asserted between edges mid-UP -> outputs reach reset values without a clock edge, and start after release begins a fresh program.
